// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract controller.
// The master side issues requests; the slave side (the controller) returns status and results.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             ovf;

    modport master (
        output start, sub, a_in, b_in,
        input  busy, done, result, carry_out, ovf
    );

    modport slave (
        input  start, sub, a_in, b_in,
        output busy, done, result, carry_out, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell is stepped over the
// operand pair LSB first, one bit per clock, with a registered carry.
// Subtraction uses two's complement (B inverted on load, carry-in forced to 1).

// Single full-adder cell shared by every bit position.
module fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_clr_n,
    serial_adder_ctrl_if.slave   io_bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_r_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_c_ff;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_ovf;

    logic             w_sum;
    logic             w_carry;
    logic             w_accept;
    logic             w_last;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // A new request is only taken while no operation is in flight.
    assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_FIN)) && io_bus.start;
    assign w_last   = (r_cnt == LAST_BIT);

    fa u_fa (
        .i_a     (r_a_sr[0]),
        .i_b     (r_b_sr[0]),
        .i_c     (r_c_ff),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: FIN behaves like IDLE toward a new request, giving back-to-back ops.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  begin
                if (io_bus.start) w_state_nxt = ST_SHIFT;
                else              w_state_nxt = ST_IDLE;
            end
            ST_SHIFT: begin
                if (w_last) w_state_nxt = ST_FIN;
                else        w_state_nxt = ST_SHIFT;
            end
            ST_FIN:   begin
                if (io_bus.start) w_state_nxt = ST_SHIFT;
                else              w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so BUSY/DONE come straight from flops.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            ST_SHIFT: w_busy_nxt = 1'b1;
            ST_FIN:   w_done_nxt = 1'b1;
            default:  begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Status output registers.
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Operand load, per-bit shifting and capture of the final result on the last bit.
    // r_c_ff during the last bit is the carry into the MSB, so it is XORed with the
    // carry out of the MSB to form the signed-overflow flag.
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_a_sr      <= {WIDTH{1'b0}};
            r_b_sr      <= {WIDTH{1'b0}};
            r_r_sr      <= {WIDTH{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_c_ff      <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_carry_out <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_accept) begin
            r_a_sr <= io_bus.a_in;
            r_b_sr <= io_bus.sub ? ~io_bus.b_in : io_bus.b_in;
            r_c_ff <= io_bus.sub;
            r_cnt  <= {CW{1'b0}};
        end else if (r_state == ST_SHIFT) begin
            r_r_sr <= {w_sum, r_r_sr[WIDTH-1:1]};
            r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_c_ff <= w_carry;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
                r_result    <= {w_sum, r_r_sr[WIDTH-1:1]};
                r_carry_out <= w_carry;
                r_ovf       <= r_c_ff ^ w_carry;
            end else begin
                r_result    <= r_result;
                r_carry_out <= r_carry_out;
                r_ovf       <= r_ovf;
            end
        end else begin
            r_a_sr <= r_a_sr;
            r_b_sr <= r_b_sr;
        end
    end

    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.result    = r_result;
    assign io_bus.carry_out = r_carry_out;
    assign io_bus.ovf       = r_ovf;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus random
// add/subtract operations checked against an arithmetic reference model.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk;
    logic clr_n;
    int   total;
    int   bad;

    logic [W-1:0] exp_res;
    logic         exp_c;
    logic         exp_v;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_clr_n (clr_n),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; returns {ovf, carry, result}.
    function automatic logic [W+1:0] ref_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ua;
        int unsigned ub;
        int unsigned usum;
        int          sa;
        int          sb;
        int          s;
        logic [W-1:0] res;
        logic        c;
        logic        v;
        ua = a;
        ub = sub ? ((2**W - 1) - b) : b;
        usum = ua + ub + (sub ? 1 : 0);
        res = usum[W-1:0];
        c = usum[W];
        sa = $signed(a);
        sb = $signed(b);
        s = sub ? (sa - sb) : (sa + sb);
        v = (s > (2**(W-1) - 1)) || (s < -(2**(W-1)));
        return {v, c, res};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and follow it to completion; poke>=0 re-pulses START
    // with a different A during that SHIFT cycle.
    task automatic run_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke, input string tag);
        logic [W+1:0] r;
        r = ref_op(sub, a, b);
        bus.start = 1'b1;
        bus.sub   = sub;
        bus.a_in  = a;
        bus.b_in  = b;
        tick();
        for (int i = 0; i < W; i++) begin
            bus.start = (i == poke);
            bus.a_in  = (i == poke) ? 8'hAA : W'($urandom);
            bus.b_in  = W'($urandom);
            bus.sub   = 1'($urandom);
            total++;
            if ({bus.busy, bus.done} !== 2'b10) begin
                bad++;
                $display("FAIL %s shift%0d busy/done got=%b exp=10", tag, i, {bus.busy, bus.done});
            end
            total++;
            if ({bus.ovf, bus.carry_out, bus.result} !== {exp_v, exp_c, exp_res}) begin
                bad++;
                $display("FAIL %s hold%0d got=%h exp=%h", tag, i,
                         {bus.ovf, bus.carry_out, bus.result}, {exp_v, exp_c, exp_res});
            end
            tick();
        end
        bus.start = 1'b0;
        total++;
        if ({bus.busy, bus.done} !== 2'b01) begin
            bad++;
            $display("FAIL %s done busy/done got=%b exp=01", tag, {bus.busy, bus.done});
        end
        total++;
        if ({bus.ovf, bus.carry_out, bus.result} !== r) begin
            bad++;
            $display("FAIL %s result {ovf,c,res} got=%h exp=%h", tag,
                     {bus.ovf, bus.carry_out, bus.result}, r);
        end
        {exp_v, exp_c, exp_res} = r;
        tick();
        total++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            bad++;
            $display("FAIL %s idle busy/done got=%b exp=00", tag, {bus.busy, bus.done});
        end
        total++;
        if ({bus.ovf, bus.carry_out, bus.result} !== r) begin
            bad++;
            $display("FAIL %s held got=%h exp=%h", tag, {bus.ovf, bus.carry_out, bus.result}, r);
        end
    endtask

    task automatic test_reset();
        clr_n     = 1'b0;
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a_in  = 8'hFF;
        bus.b_in  = 8'hFF;
        tick();
        tick();
        tick();
        total++;
        if ({bus.busy, bus.done, bus.ovf, bus.carry_out, bus.result} !== 12'h000) begin
            bad++;
            $display("FAIL reset outputs got=%h exp=000",
                     {bus.busy, bus.done, bus.ovf, bus.carry_out, bus.result});
        end
        clr_n     = 1'b1;
        bus.start = 1'b0;
        tick();
        total++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            bad++;
            $display("FAIL reset_release busy/done got=%b exp=00", {bus.busy, bus.done});
        end
        exp_res = 8'h00;
        exp_c   = 1'b0;
        exp_v   = 1'b0;
    endtask

    task automatic test_add_vectors();
        run_op(1'b0, 8'h35, 8'h4A, -1, "add_35_4a");
        run_op(1'b0, 8'hFF, 8'h01, -1, "add_ff_01");
        run_op(1'b0, 8'h7F, 8'h01, -1, "add_7f_01");
    endtask

    task automatic test_sub_vectors();
        run_op(1'b1, 8'h10, 8'h01, -1, "sub_10_01");
        run_op(1'b1, 8'h00, 8'h01, -1, "sub_00_01");
        run_op(1'b1, 8'h80, 8'h01, -1, "sub_80_01");
    endtask

    task automatic test_ignore_start();
        run_op(1'b0, 8'h01, 8'h01, 3, "ignore_start");
        total++;
        if (exp_res !== 8'h02) begin
            bad++;
            $display("FAIL ignore_start model got=%h exp=02", exp_res);
        end
    endtask

    task automatic test_back_to_back();
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a_in  = 8'h10;
        bus.b_in  = 8'h20;
        tick();
        for (int op = 0; op < 3; op++) begin
            for (int i = 0; i < W; i++) begin
                total++;
                if ({bus.busy, bus.done} !== 2'b10) begin
                    bad++;
                    $display("FAIL b2b op%0d shift%0d busy/done got=%b exp=10", op, i, {bus.busy, bus.done});
                end
                tick();
            end
            total++;
            if ({bus.busy, bus.done, bus.ovf, bus.carry_out, bus.result} !== {4'b0100, 8'h30}) begin
                bad++;
                $display("FAIL b2b op%0d done got=%h exp=%h", op,
                         {bus.busy, bus.done, bus.ovf, bus.carry_out, bus.result}, {4'b0100, 8'h30});
            end
            if (op == 2) bus.start = 1'b0;
            tick();
        end
        total++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            bad++;
            $display("FAIL b2b stop busy/done got=%b exp=00", {bus.busy, bus.done});
        end
        exp_res = 8'h30;
        exp_c   = 1'b0;
        exp_v   = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        run_op(1'b0, 8'h35, 8'h4A, -1, "pre_reset");
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a_in  = 8'h12;
        bus.b_in  = 8'h34;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        total++;
        if ({bus.busy, bus.done, bus.ovf, bus.carry_out, bus.result} !== 12'h000) begin
            bad++;
            $display("FAIL mid_reset outputs got=%h exp=000",
                     {bus.busy, bus.done, bus.ovf, bus.carry_out, bus.result});
        end
        for (int i = 0; i < W + 2; i++) begin
            tick();
            total++;
            if ({bus.busy, bus.done} !== 2'b00) begin
                bad++;
                $display("FAIL mid_reset quiet%0d busy/done got=%b exp=00", i, {bus.busy, bus.done});
            end
        end
        exp_res = 8'h00;
        exp_c   = 1'b0;
        exp_v   = 1'b0;
        run_op(1'b0, 8'h35, 8'h4A, -1, "post_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            run_op(1'($urandom), W'($urandom), W'($urandom), -1, "random");
        end
        run_op(1'b1, 8'h00, 8'h80, -1, "sub_00_80");
        run_op(1'b0, 8'h80, 8'h80, -1, "add_80_80");
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        clr_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a_in  = 8'h00;
        bus.b_in  = 8'h00;
        exp_res   = 8'h00;
        exp_c     = 1'b0;
        exp_v     = 1'b0;
        test_reset();
        test_add_vectors();
        test_sub_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
